// File: rtl/sweep_scheduler_pkg.sv
// sweep_scheduler_pkg: shared state encoding, angle constants and helpers for the sweep scheduler
package sweep_scheduler_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE,
    ST_PING,
    ST_WAIT,
    ST_CONV,
    ST_OUT,
    ST_ADV
  } state_t;
  localparam int NUM_ANGLES = 6;
  localparam logic [2:0] MAX_IDX = 3'(NUM_ANGLES - 1);
  localparam logic POS = 1'b0;
  localparam logic NEG = 1'b1;
  localparam logic [3:0] TH_15  = 4'h1;
  localparam logic [3:0] TH_45  = 4'h3;
  localparam logic [3:0] TH_75  = 4'h5;
  localparam logic [3:0] TH_105 = 4'h7;
  localparam logic [3:0] TH_135 = 4'h9;
  localparam logic [3:0] TH_165 = 4'hB;
  function automatic logic [3:0] theta_of(input logic [2:0] idx);
    return {idx, 1'b1};
  endfunction
endpackage

// File: rtl/sweep_scheduler_conv.sv
// polar_to_cartesian: maps {theta code, r} to sign-magnitude x/y using 8-bit fixed-point sines
module polar_to_cartesian
  import sweep_scheduler_pkg::*;
(
  input  logic [3:0] theta_i,
  input  logic [7:0] r_i,
  output logic [8:0] x_o,
  output logic [8:0] y_o
);
  logic       outer, diag, x_neg;
  logic [7:0] kx, ky;
  always_comb begin
    outer = (theta_i == TH_15) || (theta_i == TH_165);
    diag  = (theta_i == TH_45) || (theta_i == TH_135);
    x_neg = (theta_i == TH_105) || (theta_i == TH_135) || (theta_i == TH_165);
    kx    = outer ? 8'd247 : diag ? 8'd181 : 8'd66;
    ky    = outer ? 8'd66 : diag ? 8'd181 : 8'd247;
    x_o   = {x_neg ? NEG : POS, 8'(({8'd0, r_i} * {8'd0, kx}) >> 8)};
    y_o   = {POS, 8'(({8'd0, r_i} * {8'd0, ky}) >> 8)};
  end
endmodule

// File: rtl/sweep_scheduler.sv
// sweep_scheduler: steps the servo across six angles, pings the ranger and streams converted points
module sweep_scheduler
  import sweep_scheduler_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2_700_000,
  parameter int TIMEOUT_CYCLES = 1_350_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  output logic [3:0]  servo_theta,
  output logic        range_start,
  input  logic        range_valid,
  input  logic [7:0]  range_value,
  output logic        point_valid,
  input  logic        point_ready,
  output logic [8:0]  point_x,
  output logic [8:0]  point_y,
  output logic [11:0] point_r_theta,
  output logic        point_timeout,
  output logic        sweep_done,
  output logic        busy
);
  localparam int MAXC = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SETTLE_LD  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYCLES - 1);
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q, idx_d;
  logic          dir_q, dir_d, at_end;
  logic [3:0]    servo_q;
  logic          rs_q, to_q, pv_q, pto_q, sd_q, busy_q;
  logic [11:0]   lat_q, prt_q;
  logic [8:0]    px_q, py_q, cx, cy;
  always_comb begin
    at_end = dir_q ? (idx_q == 3'd0) : (idx_q == MAX_IDX);
    idx_d  = at_end ? idx_q : dir_q ? idx_q - 3'd1 : idx_q + 3'd1;
    dir_d  = at_end ? ~dir_q : dir_q;
  end
  polar_to_cartesian u_conv (
    .theta_i(lat_q[11:8]),
    .r_i    (lat_q[7:0]),
    .x_o    (cx),
    .y_o    (cy)
  );
  // timeout is checked before range_valid so a coincident pulse loses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      dir_q   <= 1'b0;
      servo_q <= TH_15;
      rs_q    <= 1'b0;
      lat_q   <= '0;
      to_q    <= 1'b0;
      pv_q    <= 1'b0;
      prt_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pto_q   <= 1'b0;
      sd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rs_q <= 1'b0;
      sd_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (enable) begin
          state_q <= ST_MOVE;
          cnt_q   <= SETTLE_LD;
          servo_q <= theta_of(idx_q);
          busy_q  <= 1'b1;
        end
        ST_MOVE: if (cnt_q == '0) state_q <= ST_PING;
                 else cnt_q <= cnt_q - 1'b1;
        ST_PING: begin
          rs_q    <= 1'b1;
          cnt_q   <= TIMEOUT_LD;
          state_q <= ST_WAIT;
        end
        ST_WAIT: if (cnt_q == '0) begin
          lat_q   <= {theta_of(idx_q), 8'd0};
          to_q    <= 1'b1;
          state_q <= ST_CONV;
        end else begin
          cnt_q <= cnt_q - 1'b1;
          if (range_valid) begin
            lat_q   <= {theta_of(idx_q), range_value};
            to_q    <= 1'b0;
            state_q <= ST_CONV;
          end
        end
        ST_CONV: begin
          prt_q   <= lat_q;
          px_q    <= cx;
          py_q    <= cy;
          pto_q   <= to_q;
          pv_q    <= 1'b1;
          state_q <= ST_OUT;
        end
        ST_OUT: if (point_ready) begin
          pv_q    <= 1'b0;
          sd_q    <= at_end;
          state_q <= ST_ADV;
        end
        ST_ADV: begin
          idx_q <= idx_d;
          dir_q <= dir_d;
          if (enable) begin
            state_q <= ST_MOVE;
            cnt_q   <= SETTLE_LD;
            servo_q <= theta_of(idx_d);
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign servo_theta   = servo_q;
  assign range_start   = rs_q;
  assign point_valid   = pv_q;
  assign point_x       = px_q;
  assign point_y       = py_q;
  assign point_r_theta = prt_q;
  assign point_timeout = pto_q;
  assign sweep_done    = sd_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_sweep_scheduler.sv
// tb_sweep_scheduler: directed sweep stimulus with a queue-based point scoreboard
module tb_sweep_scheduler;
  typedef struct packed {
    logic [11:0] rt;
    logic [8:0]  x;
    logic [8:0]  y;
    logic        to;
    logic        sd;
  } exp_t;
  logic        clock, reset_n, enable, range_start, range_valid, point_valid, point_ready;
  logic        point_timeout, sweep_done, busy;
  logic [3:0]  servo_theta;
  logic [7:0]  range_value;
  logic [8:0]  point_x, point_y;
  logic [11:0] point_r_theta;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  sweep_scheduler #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(10)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .servo_theta  (servo_theta),
    .range_start  (range_start),
    .range_valid  (range_valid),
    .range_value  (range_value),
    .point_valid  (point_valid),
    .point_ready  (point_ready),
    .point_x      (point_x),
    .point_y      (point_y),
    .point_r_theta(point_r_theta),
    .point_timeout(point_timeout),
    .sweep_done   (sweep_done),
    .busy         (busy)
  );
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic exp_t mk(input logic [3:0] th, input logic [7:0] r, input logic to, input logic sd);
    int kx, ky;
    kx = (th == 4'h1 || th == 4'hB) ? 247 : (th == 4'h3 || th == 4'h9) ? 181 : 66;
    ky = (th == 4'h1 || th == 4'hB) ? 66 : (th == 4'h3 || th == 4'h9) ? 181 : 247;
    mk.rt = {th, r};
    mk.x  = {th >= 4'h7, 8'((32'(r) * kx) >> 8)};
    mk.y  = {1'b0, 8'((32'(r) * ky) >> 8)};
    mk.to = to;
    mk.sd = sd;
  endfunction
  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!range_start && n < 100);
    if (!range_start) chk("range_start_seen", 64'(range_start), 64'(1));
  endtask
  task automatic respond(input logic [7:0] r);
    @(negedge clock);
    chk("start_one_cycle", 64'(range_start), 64'(0));
    range_valid = 1'b1;
    range_value = r;
    @(negedge clock);
    range_valid = 1'b0;
    chk("lat_pv_low", 64'(point_valid), 64'(0));
    @(negedge clock);
    chk("lat_pv_high", 64'(point_valid), 64'(1));
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("drain", 64'(q.size()), 64'(0));
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (point_valid && point_ready) begin
        if (q.size() == 0) chk("unexpected_point", 64'(1), 64'(0));
        else begin
          e = q.pop_front();
          chk("r_theta", 64'(point_r_theta), 64'(e.rt));
          chk("x", 64'(point_x), 64'(e.x));
          chk("y", 64'(point_y), 64'(e.y));
          chk("timeout", 64'(point_timeout), 64'(e.to));
          @(posedge clock);
          #1;
          chk("sweep_done", 64'(sweep_done), 64'(e.sd));
        end
      end
    end
  end
  initial begin
    logic [3:0] th_tab[13] = '{4'h1, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hB, 4'h9, 4'h7, 4'h5, 4'h3, 4'h1, 4'h1};
    logic [7:0] r_tab[13]  = '{8'd100, 8'd10, 8'd20, 8'd40, 8'd200, 8'd0, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd120, 8'd130};
    logic [36:0] snap;
    int n;
    reset_n = 1'b0;
    enable = 1'b0;
    range_valid = 1'b0;
    range_value = 8'd0;
    point_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_servo", 64'(servo_theta), 64'(4'h1));
    chk("rst_outputs", 64'({range_start, point_valid, point_timeout, sweep_done, busy}), 64'(0));
    chk("rst_point", 64'({point_r_theta, point_x, point_y}), 64'(0));
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("idle_busy", 64'({busy, range_start, point_valid}), 64'(0));
    chk("idle_servo", 64'(servo_theta), 64'(4'h1));
    point_ready = 1'b1;
    enable = 1'b1;
    wait_start(n);
    chk("first_start_latency", 64'(n), 64'(6));
    chk("servo_0", 64'(servo_theta), 64'(4'h1));
    q.push_back(exp_t'{12'h164, 9'h060, 9'h019, 1'b0, 1'b0});
    respond(8'd100);
    for (int i = 1; i < 13; i++) begin
      wait_start(n);
      chk("servo_seq", 64'(servo_theta), 64'(th_tab[i]));
      if (i == 5) begin
        q.push_back(exp_t'{12'hB00, 9'h100, 9'h000, 1'b1, 1'b1});
        repeat (9) @(negedge clock);
        range_valid = 1'b1;
        range_value = 8'd77;
        @(negedge clock);
        range_valid = 1'b0;
        chk("to_pv_low", 64'(point_valid), 64'(0));
        @(negedge clock);
        chk("to_pv_11_edges", 64'(point_valid), 64'(1));
        @(negedge clock);
        range_valid = 1'b1;
        @(negedge clock);
        range_valid = 1'b0;
      end else begin
        if (i == 4) q.push_back(exp_t'{12'h9C8, 9'h18D, 9'h08D, 1'b0, 1'b0});
        else q.push_back(mk(th_tab[i], r_tab[i], 1'b0, i == 11));
        respond(r_tab[i]);
      end
    end
    drain();
    point_ready = 1'b0;
    wait_start(n);
    enable = 1'b0;
    q.push_back(mk(4'h3, 8'd30, 1'b0, 1'b0));
    respond(8'd30);
    snap = {point_valid, point_r_theta, point_x, point_y, point_timeout, busy, servo_theta};
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("hold_stable", 64'({point_valid, point_r_theta, point_x, point_y, point_timeout, busy, servo_theta}), 64'(snap));
    end
    point_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("park_busy", 64'({busy, point_valid}), 64'(0));
    chk("park_servo", 64'(servo_theta), 64'(4'h3));
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (range_start) n++;
    end
    chk("park_no_start", 64'(n), 64'(0));
    enable = 1'b1;
    wait_start(n);
    chk("resume_latency", 64'(n), 64'(6));
    chk("resume_servo", 64'(servo_theta), 64'(4'h5));
    q.push_back(mk(4'h5, 8'd140, 1'b0, 1'b0));
    respond(8'd140);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sweep_scheduler.md
# sweep_scheduler

Sequences the ultrasound range sweep across the six fixed angles (15° + 30n, n = 0..5). For each angle it drives the servo angle code, waits a settle time, triggers one range measurement, passes the measured range and angle through the existing polar-to-Cartesian converter, and presents the resulting point on a valid/ready stream to the display/tracking logic. Sweeps alternate direction (up, then down), so the servo never jumps from 165° back to 15°.

## Interface
- `SETTLE_CYCLES`, default 2_700_000: cycles held at a new angle before pinging (100 ms at 27 MHz); minimum 1.
- `TIMEOUT_CYCLES`, default 1_350_000: cycles to wait for `range_valid` after a ping; minimum 1.
- `clock`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run sweeps while high.
- `servo_theta`  out  4  angle code to the servo driver; only 1, 3, 5, 7, 9, B (15°..165°).
- `range_start`  out  1  one-cycle pulse that starts a measurement.
- `range_valid`  in  1  one-cycle pulse: `range_value` is valid.
- `range_value`  in  8  measured range r.
- `point_valid`  out  1  a point is held on the `point_*` outputs.
- `point_ready`  in  1  consumer accepts the point.
- `point_x`, `point_y`  out  9 each  sign-magnitude: bit 8 is the sign (1 = negative), bits 7:0 are the magnitude.
- `point_r_theta`  out  12  {theta code[11:8], r[7:0]} of the point.
- `point_timeout`  out  1  the point came from a timeout (r forced to 0).
- `sweep_done`  out  1  one-cycle pulse when the last point of a sweep is accepted.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Angle index idx runs 0..5. The angle code is theta = 2·idx + 1.
- Direction bit dir: 0 = up, 1 = down.
- States and transitions:
  - IDLE: if `enable`, go to MOVE.
  - MOVE: drive `servo_theta`, load the counter with SETTLE_CYCLES−1, count down; at 0 go to PING.
  - PING: assert `range_start` for one cycle, load the counter with TIMEOUT_CYCLES−1, go to WAIT.
  - WAIT, on `range_valid`: latch r = `range_value`, clear the timeout flag, go to CONV.
  - WAIT, counter reaches 0 with no `range_valid`: r = 0, set the timeout flag, go to CONV.
  - CONV: register {theta, r} and the converter outputs into the `point_*` registers, set `point_valid`, go to OUT.
  - OUT: hold all `point_*` outputs stable until `point_valid` && `point_ready`. On that handshake go to ADV.
  - ADV: pick the next index and go to MOVE, or go to IDLE if `enable` is low.
- Next-index rule in ADV:
  - up and idx < 5: idx + 1.
  - down and idx > 0: idx − 1.
  - At an endpoint: toggle dir and keep idx. The endpoint angle is measured again at the start of the next sweep, with full settle.
- `sweep_done` pulses in the same cycle as the handshake when it completes idx 5 (going up) or idx 0 (going down).
- `range_valid` is ignored in every state except WAIT, including a pulse in the same cycle as the timeout expiry; the timeout wins.
- Dropping `enable` does not abort a point. The current point finishes through the OUT handshake, then the block parks in IDLE with idx, dir and `servo_theta` retained. Re-enabling resumes at MOVE for the next index.
- A reset mid-operation drops any pending point with no handshake.
- Values on reset: state IDLE, idx 0, dir up, `servo_theta` = 4'h1. `range_start`, `point_valid`, `point_x`, `point_y`, `point_r_theta`, `point_timeout`, `sweep_done` and `busy` are all 0.
- Arithmetic is unchanged from the converter:
  - mag(r·sin15°) = (r·66) >> 8.
  - mag(r·sin45°) = (r·181) >> 8.
  - mag(r·sin75°) = (r·247) >> 8.
  - x is negative for theta codes 7, 9, B; y is always positive.

## Timing
- A single shared down-counter serves both settle and timeout. It must be at least ceil(log2(max(SETTLE_CYCLES, TIMEOUT_CYCLES))) bits wide.
- The first `range_start` comes SETTLE_CYCLES + 2 cycles after `enable` is sampled high in IDLE.
- `range_valid` is sampled at edge N. `point_valid` is high from the cycle after edge N+1. Latency is 2 edges.
- Timeout: `point_valid` rises TIMEOUT_CYCLES + 1 edges after the PING edge.
- `point_ready` may be held high constantly. Each point then takes one OUT cycle, and ADV takes one cycle.
- All outputs are registered; there is no combinational path from an input to an output.

## Structure
- A shared package holds:
  - the state encoding (IDLE, MOVE, PING, WAIT, CONV, OUT, ADV);
  - NUM_ANGLES = 6, MAX_IDX = 5;
  - the sign constants POS = 0, NEG = 1;
  - the theta-code constants.
- One sub-module instance: the existing `polar_to_cartesian` converter, fed from the latched {theta, r} register.
- The counter, index/direction logic and FSM stay inline.

## Test plan
Bench parameters: SETTLE_CYCLES = 4, TIMEOUT_CYCLES = 10.
- Reset low, then release with `enable` = 0 → outputs match the reset values, `servo_theta` = 1, `busy` = 0 indefinitely.
- Enable; return r = 100 one cycle after the first `range_start` → `point_r_theta` = 12'h164, `point_x` = 9'h060, `point_y` = 9'h019, `point_timeout` = 0.
- Drive to idx 4, r = 200 → `point_r_theta` = 12'h9C8, `point_x` = 9'h18D, `point_y` = 9'h08D.
- Never assert `range_valid` → point with r = 0, x = y = 0 (x sign 1 at theta codes 7, 9, B), `point_timeout` = 1 exactly 11 edges after PING; a late `range_valid` is ignored.
- Full sweep with `point_ready` = 1 → theta sequence 1,3,5,7,9,B,B,9,7,5,3,1,1; `sweep_done` pulses after the 6th and 12th points.
- Hold `point_ready` = 0 for 20 cycles in OUT with `enable` dropped → outputs stable. After ready, go to IDLE with `servo_theta` retained; re-enable → next index, and no `range_start` before the settle expires.
